mem_bist: RTL

Synthesizable, parametrised memory self-test engine that drives the SDRAM controller's go/valid request port. It replaces the hand-written write-then-read bench loop with an on-chip sequencer: it writes a deterministic pattern across a programmable address range, reads it back, compares, and reports pass/fail, error count and first failing location. It sits between the top-level control logic and `mem_con`, sharing that controller's request interface.

---
 rtl/mem_bist.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bist.sv
// -----------------------------------------------------------------------------
// mem_bist -- on-chip memory self-test sequencer for the mem_con request port.
//
// Writes a deterministic pattern over a programmable address window, reads it
// back, compares each word and reports pass/fail, a saturating error count and
// the first failing location. An optional second pass repeats the test with
// the inverted pattern.
//
// Pattern for word offset a (0..num_words) in pass p:
//   P(a) = seed + zero_extend(a)   (mod 2^DATA_W), inverted when p = 1
// The request address is base_addr + a (mod 2^ADDR_W).
//
// Parameters:
//   DATA_W     controller data width
//   ADDR_W     controller address width
//   ERR_W      error counter width (saturates at all-ones)
//   INTERLEAVE 0: write whole window, then read it; 1: write/read per address
//   TIMEOUT    cycles a request may wait for mem_valid before aborting (>= 2)
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   start                    one-cycle pulse, accepted only when idle
//   seed, base_addr,
//   num_words, invert_pass   test setup, sampled on accepted start
//   busy, done               test running / one-cycle end-of-test pulse
//   pass, timeout            result flags (valid when not busy)
//   err_count                mismatch count of the last test
//   first_err_addr/_data     address and read data of the first mismatch
//   mem_go, mem_w_rn,
//   mem_address,
//   mem_data_to_write        request to controller, held stable while mem_go
//   mem_data_to_read,
//   mem_valid                controller completion (read data with mem_valid)
// -----------------------------------------------------------------------------
module mem_bist #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 13,
  parameter int ERR_W      = 16,
  parameter int INTERLEAVE = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              invert_pass,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              mem_go,
  output logic              mem_w_rn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_to_write,
  input  logic [DATA_W-1:0] mem_data_to_read,
  input  logic              mem_valid
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t            state;

  // Test setup captured at start
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_idx;
  logic              inv_en;

  // Position in the request sequence
  logic [ADDR_W-1:0] idx;      // word offset from base
  logic              is_rd;    // current request is a read
  logic              inv;      // current pass uses the inverted pattern
  logic [WAIT_W-1:0] wait_cnt;

  // Next position and end-of-sequence flag
  logic [ADDR_W-1:0] nxt_idx;
  logic              nxt_rd;
  logic              nxt_inv;
  logic              last_req;
  logic [DATA_W-1:0] exp_data;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a,
                                                input logic              i);
    return (s + DATA_W'(a)) ^ {DATA_W{i}};
  endfunction

  // Sequence advance. Both orders end on the read of the last word in the
  // final pass; only the order in which (idx, is_rd) are stepped differs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nxt_idx  = idx;
    nxt_rd   = is_rd;
    nxt_inv  = inv;
    last_req = is_rd && (idx == last_idx) && (inv == inv_en);
    if (INTERLEAVE != 0) begin
      if (!is_rd) begin
        nxt_rd = 1'b1;
      end else begin
        nxt_rd = 1'b0;
        if (idx == last_idx) begin
          nxt_idx = '0;
          nxt_inv = 1'b1;
        end else begin
          nxt_idx = idx + ADDR_W'(1);
        end
      end
    end else begin
      if (idx == last_idx) begin
        nxt_idx = '0;
        if (!is_rd) begin
          nxt_rd = 1'b1;
        end else begin
          nxt_rd  = 1'b0;
          nxt_inv = 1'b1;
        end
      end else begin
        nxt_idx = idx + ADDR_W'(1);
      end
    end
  end

  assign exp_data = pattern(seed_q, idx, inv);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      seed_q            <= '0;
      base_q            <= '0;
      last_idx          <= '0;
      inv_en            <= 1'b0;
      idx               <= '0;
      is_rd             <= 1'b0;
      inv               <= 1'b0;
      wait_cnt          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      timeout           <= 1'b0;
      err_count         <= '0;
      first_err_addr    <= '0;
      first_err_data    <= '0;
      mem_go            <= 1'b0;
      mem_w_rn          <= 1'b0;
      mem_address       <= '0;
      mem_data_to_write <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed_q            <= seed;
            base_q            <= base_addr;
            last_idx          <= num_words;
            inv_en            <= invert_pass;
            idx               <= '0;
            is_rd             <= 1'b0;
            inv               <= 1'b0;
            wait_cnt          <= '0;
            err_count         <= '0;
            first_err_addr    <= '0;
            first_err_data    <= '0;
            timeout           <= 1'b0;
            pass              <= 1'b0;
            busy              <= 1'b1;
            // First request is issued straight from the start inputs.
            mem_go            <= 1'b1;
            mem_w_rn          <= 1'b1;
            mem_address       <= base_addr;
            mem_data_to_write <= pattern(seed, '0, 1'b0);
            state             <= REQ;
          end
        end

        REQ: begin
          if (mem_valid) begin
            if (!mem_w_rn && (mem_data_to_read != exp_data)) begin
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              // Counter saturates and never returns to zero, so zero marks
              // the first mismatch of this test.
              if (err_count == '0) begin
                first_err_addr <= mem_address;
                first_err_data <= mem_data_to_read;
              end
            end
            mem_go <= 1'b0;
            state  <= GAP;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // Abort: controller never answered this request.
            timeout <= 1'b1;
            mem_go  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        GAP: begin
          if (last_req) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !timeout;
            state <= DONE;
          end else begin
            idx               <= nxt_idx;
            is_rd             <= nxt_rd;
            inv               <= nxt_inv;
            wait_cnt          <= '0;
            mem_go            <= 1'b1;
            mem_w_rn          <= !nxt_rd;
            mem_address       <= base_q + nxt_idx;
            mem_data_to_write <= pattern(seed_q, nxt_idx, nxt_inv);
            state             <= REQ;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
